pipe_arbiter: RTL and testbench
===============================

// Module: pipe_arbiter
// PURPOSE
//  Round-robin controller that shares one fixed-latency pipelined datapath (a CYCLES-deep register chain) among NUM_REQ requesters.
//  Grants one valid/ready transfer per cycle, drives the datapath input, and tracks requester tags in a parallel CYCLES-deep valid/tag shift chain.
//  Routes each result back to its originator exactly CYCLES cycles after issue. Sits between client blocks and the shared delay/compute stage.
// PARAMETERS
//  WIDTH    8   data width of requests, datapath and responses
//  CYCLES   4   datapath latency in clocks (>=1); depth of internal tag chain
//  NUM_REQ  4   number of requesters (>=2); TAG_W = $clog2(NUM_REQ), localparam
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous reset, active-low
//  en         in   1              1 = accept new requests; 0 = stop granting, drain in-flight ops
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_data   in   NUM_REQ*WIDTH  request payloads; requester i at [i*WIDTH +: WIDTH]
//  req_ready  out  NUM_REQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
//  pipe_valid out  1              datapath input valid (= a transfer occurred this cycle)
//  pipe_din   out  WIDTH          datapath input = granted requester's payload; 0 when no transfer
//  pipe_dout  in   WIDTH          datapath output, arriving CYCLES clocks after pipe_din
//  rsp_valid  out  NUM_REQ        one-hot response strobe to originating requester
//  rsp_data   out  WIDTH          = pipe_dout when any rsp_valid, else 0
//  idle       out  1              1 when FSM in IDLE
//  grant_cnt  out  NUM_REQ*16     per-requester grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0, async): tag chain valids cleared, rr pointer=0, FSM=IDLE, counters=0; all outputs 0 except idle=1.
//  FSM: IDLE -> RUN when en=1. RUN -> DRAIN when en=0 and inflight>0; RUN -> IDLE when en=0 and inflight==0.
//   DRAIN -> RUN when en=1; DRAIN -> IDLE when inflight==0 and en=0. Grants issued only in RUN, or IDLE with en=1 (same-cycle start).
//  inflight = popcount of tag chain valids, range 0..CYCLES; never overflows (one issue, one retire per cycle max).
//  Arbitration: combinational round-robin over req_valid, search starts at rr pointer; at most one req_ready high.
//   req_ready is 0 for all when not granting. After a transfer from i, pointer = (i+1) mod NUM_REQ; unchanged if no transfer.
//  Handshake: requester holds req_valid and req_data stable until accepted; req_ready may depend on req_valid (no comb loop on requester side permitted).
//  Issue: transfer at cycle t -> pipe_valid=1, pipe_din=payload in cycle t; tag chain stage0 <= {1,tag} at edge ending t.
//  Retire: chain stage CYCLES-1 valid in cycle t+CYCLES -> rsp_valid[tag]=1, rsp_data=pipe_dout (combinational, same cycle).
//  Throughput: 1 op/cycle sustained; responses never back-pressured (fixed latency, no rsp_ready).
//  Simultaneous issue+retire: both occur; inflight unchanged.
//  en drop mid-stream: no new grants next cycle onward (en sampled combinationally); all in-flight ops still retire.
//  Reset mid-operation: all in-flight tags discarded; no rsp_valid for them after reset release.
//  Boundary: NUM_REQ not power of 2 -> unused tag codes never generated. CYCLES=1 -> response the cycle after issue.
// CONFIGURATION
//  PIPE_ARB_GRANT_CNT_EN defined: grant_cnt[i*16 +: 16] increments on every transfer from requester i, saturates at 16'hFFFF, cleared by rst.
//  Not defined: counter logic not built; grant_cnt tied to 0.
// TESTING
//  1. Reset: rst=0 with req_valid=4'hF -> req_ready=0, rsp_valid=0, idle=1; release with en=0 -> still no grants.
//  2. Single op: en=1, req_valid=4'b0100, req_data[2]=8'hA5 -> req_ready=4'b0100 same cycle; 4 cycles later rsp_valid=4'b0100, rsp_data=8'hA5 (datapath = 4-deep delay).
//  3. Fairness: req_valid=4'hF held for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in same order, one per cycle, 4 cycles delayed.
//  4. Drain: 3 ops issued, then en=0 -> no further req_ready, FSM DRAIN, 3 responses retire, idle=1 one cycle after last retire.
//  5. Reset mid-flight: issue 2 ops, assert rst 2 cycles later -> no rsp_valid ever for them; rr pointer back to 0 (next grant to requester 0).
//  6. With PIPE_ARB_GRANT_CNT_EN: 5 transfers from requester 1 -> grant_cnt[31:16]=5, others 0; force 70000 grants -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_arbiter.sv
// Round-robin front end for a shared fixed-latency datapath, with a tag chain that routes each result back to its requester.
// Optional per-requester grant counters are built when PIPE_ARB_GRANT_CNT_EN is defined.
//
// state   | meaning
// S_IDLE  | nothing in flight; grants start in the same cycle en rises
// S_RUN   | granting one transfer per cycle while en=1
// S_DRAIN | en dropped with ops in flight; no grants, waiting for retirement
module pipe_arbiter #(
   parameter int WIDTH   = 8,
   parameter int CYCLES  = 4,
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       pipe_valid,
   output logic [WIDTH-1:0]           pipe_din,
   input  logic [WIDTH-1:0]           pipe_dout,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       idle,
   output logic [NUM_REQ*16-1:0]      grant_cnt
);

   localparam int TAG_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                       state_q, state_d;
   logic                         idle_q, idle_d;
   logic [TAG_W-1:0]             rr_q, rr_d;
   logic [CYCLES-1:0]            valid_q, valid_d;
   logic [CYCLES-1:0][TAG_W-1:0] tag_q, tag_d;

   logic                         granting;
   logic                         found;
   logic                         transfer;
   logic [TAG_W-1:0]             grant_idx;
   logic                         pending;

   // Search order starts at the rr pointer; rr_q is always < NUM_REQ, so unused tag codes never appear.
   always_comb begin
      granting  = rst & en & (state_q != S_DRAIN);
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
            found     = 1'b1;
            grant_idx = TAG_W'((int'(rr_q) + k) % NUM_REQ);
         end
      end
      transfer   = granting & found;
      req_ready  = transfer ? (NUM_REQ'(1) << grant_idx) : '0;
      pipe_valid = transfer;
      pipe_din   = transfer ? req_data[grant_idx*WIDTH +: WIDTH] : '0;
      rr_d       = rr_q;
      if (transfer)
         rr_d = (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
   end

   always_comb begin
      valid_d    = '0;
      tag_d      = '0;
      valid_d[0] = transfer;
      tag_d[0]   = grant_idx;
      for (int i = 1; i < CYCLES; i++) begin
         valid_d[i] = valid_q[i-1];
         tag_d[i]   = tag_q[i-1];
      end
      // Ops that will still be in flight after this cycle's retirement.
      pending = 1'b0;
      for (int i = 0; i < CYCLES-1; i++)
         pending = pending | valid_q[i];
      rsp_valid = valid_q[CYCLES-1] ? (NUM_REQ'(1) << tag_q[CYCLES-1]) : '0;
      rsp_data  = valid_q[CYCLES-1] ? pipe_dout : '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (en) state_d = S_RUN;
         S_RUN:   if (!en) state_d = pending ? S_DRAIN : S_IDLE;
         S_DRAIN: begin
            if (en)            state_d = S_RUN;
            else if (!pending) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      idle_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idle_q  <= 1'b1;
         rr_q    <= '0;
         valid_q <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         rr_q    <= rr_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign idle = idle_q;

`ifdef PIPE_ARB_GRANT_CNT_EN
   logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (transfer && cnt_q[grant_idx] != 16'hFFFF)
         cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with a 4-deep delay line standing in for the shared datapath.
module tb_pipe_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        pipe_valid;
   logic [7:0]  pipe_din;
   logic [7:0]  pipe_dout;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        idle;
   logic [63:0] grant_cnt;

   logic [7:0]  dly0, dly1, dly2, dly3;
   logic [7:0]  pay [4];
   logic [63:0] exp_gc;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      dly0 <= pipe_din;
      dly1 <= dly0;
      dly2 <= dly1;
      dly3 <= dly2;
   end
   assign pipe_dout = dly3;

   pipe_arbiter dut (
      .clk(clk), .rst(rst), .en(en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .pipe_valid(pipe_valid), .pipe_din(pipe_din), .pipe_dout(pipe_dout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle), .grant_cnt(grant_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'hA5; pay[3] = 8'h44;
      rst       = 1'b0;
      en        = 1'b0;
      req_valid = 4'hF;
      req_data  = {pay[3], pay[2], pay[1], pay[0]};

      // reset state
      #12;
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_rsp", rsp_valid, 4'h0);
      chk("rst_idle", idle, 1'b1);
      chk("rst_pvalid", pipe_valid, 1'b0);
      chk("rst_gcnt", grant_cnt, 64'h0);
      en = 1'b1;
      #1 chk("rst_ready_en", req_ready, 4'h0);
      en = 1'b0;

      @(negedge clk); rst = 1'b1; en = 1'b0;
      #1 chk("rel_ready", req_ready, 4'h0);
      @(negedge clk);
      #1 chk("rel_idle", idle, 1'b1);
      chk("rel_ready2", req_ready, 4'h0);

      // single op from requester 2
      @(negedge clk); en = 1'b1; req_valid = 4'b0100;
      #1 chk("single_ready", req_ready, 4'b0100);
      chk("single_pvalid", pipe_valid, 1'b1);
      chk("single_pdin", pipe_din, 8'hA5);
      @(negedge clk); req_valid = 4'b0000;
      #1 chk("single_run", idle, 1'b0);
      chk("single_rsp_t1", rsp_valid, 4'h0);
      for (int i = 2; i < 4; i++) begin
         @(negedge clk);
         #1 chk("single_rsp_early", rsp_valid, 4'h0);
      end
      @(negedge clk);
      #1 chk("single_rsp", rsp_valid, 4'b0100);
      chk("single_rdata", rsp_data, 8'hA5);
      @(negedge clk);
      #1 chk("single_rsp_after", rsp_valid, 4'h0);
      chk("single_rdata_after", rsp_data, 8'h00);

      // fairness, starting from a freshly reset pointer
      @(negedge clk); rst = 1'b0;
      #2 rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         chk("rr_ready", req_ready, (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
         if (c >= 4) begin
            chk("rr_rsp", rsp_valid, 4'b0001 << ((c - 4) % 4));
            chk("rr_rdata", rsp_data, pay[(c - 4) % 4]);
         end else begin
            chk("rr_rsp_none", rsp_valid, 4'h0);
         end
      end
`ifdef PIPE_ARB_GRANT_CNT_EN
      exp_gc = {16'd2, 16'd2, 16'd2, 16'd2};
`else
      exp_gc = 64'h0;
`endif
      chk("rr_gcnt", grant_cnt, exp_gc);

      // drain: three ops then en drops
      @(negedge clk); req_valid = 4'b1011;
      #1 chk("drain_g0", req_ready, 4'b0001);
      @(negedge clk); req_valid = 4'b1010;
      #1 chk("drain_g1", req_ready, 4'b0010);
      @(negedge clk); req_valid = 4'b1000;
      #1 chk("drain_g3", req_ready, 4'b1000);
      @(negedge clk); en = 1'b0; req_valid = 4'b0001;
      #1 chk("drain_nogrant", req_ready, 4'h0);
      chk("drain_pvalid", pipe_valid, 1'b0);
      @(negedge clk);
      #1 chk("drain_ready", req_ready, 4'h0);
      chk("drain_idle0", idle, 1'b0);
      chk("drain_rsp0", rsp_valid, 4'b0001);
      chk("drain_rdata0", rsp_data, 8'h11);
      @(negedge clk);
      #1 chk("drain_rsp1", rsp_valid, 4'b0010);
      chk("drain_rdata1", rsp_data, 8'h22);
      chk("drain_idle1", idle, 1'b0);
      @(negedge clk);
      #1 chk("drain_rsp3", rsp_valid, 4'b1000);
      chk("drain_rdata3", rsp_data, 8'h44);
      chk("drain_idle2", idle, 1'b0);
      @(negedge clk);
      #1 chk("drain_idle", idle, 1'b1);
      chk("drain_rsp_none", rsp_valid, 4'h0);
      chk("drain_still_off", req_ready, 4'h0);

      // reset with two ops in flight
      @(negedge clk); en = 1'b1; req_valid = 4'b0011;
      #1 chk("mid_g0", req_ready, 4'b0001);
      @(negedge clk); req_valid = 4'b0010;
      #1 chk("mid_g1", req_ready, 4'b0010);
      @(negedge clk); req_valid = 4'b0000;
      @(negedge clk); rst = 1'b0;
      #1 chk("mid_rst_idle", idle, 1'b1);
      chk("mid_rst_rsp", rsp_valid, 4'h0);
      @(negedge clk); rst = 1'b1; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("mid_no_rsp", rsp_valid, 4'h0);
         @(negedge clk);
      end
      en = 1'b1; req_valid = 4'hF;
      #1 chk("mid_ptr0", req_ready, 4'b0001);
      @(negedge clk); req_valid = 4'h0; en = 1'b0;
`ifdef PIPE_ARB_GRANT_CNT_EN
      exp_gc = {16'd0, 16'd0, 16'd0, 16'd1};
`else
      exp_gc = 64'h0;
`endif
      #1 chk("mid_gcnt", grant_cnt, exp_gc);

`ifdef PIPE_ARB_GRANT_CNT_EN
      // grant counters: count and saturation
      @(negedge clk); rst = 1'b0;
      #2 rst = 1'b1;
      #1 chk("gc_cleared", grant_cnt, 64'h0);
      @(negedge clk); en = 1'b1; req_valid = 4'b0010;
      repeat (5) @(negedge clk);
      req_valid = 4'b0000;
      #1 chk("gc_five", grant_cnt, {16'd0, 16'd0, 16'd5, 16'd0});
      @(negedge clk); req_valid = 4'b0010;
      repeat (70000) @(negedge clk);
      req_valid = 4'b0000;
      #1 chk("gc_sat", grant_cnt, {16'd0, 16'd0, 16'hFFFF, 16'd0});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
